// File: rtl/sparc_pipe_pkg.sv
// Shared pipeline definitions: default widths, skid-buffer state encoding
// and the hardwired-zero register test used by the pipeline stages.
package sparc_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int REG_AW_MAX = 16;

  // State bits are {main_v, skid_v}; 2'b01 is unreachable.
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

  // True when rd names the hardwired-zero register and that feature is enabled.
  function automatic logic is_zero_reg(input logic [REG_AW_MAX-1:0] rd,
                                       input logic                  zero_reg);
    return zero_reg & (rd == '0);
  endfunction

endpackage

// File: rtl/wb_fwd_match.sv
// One forwarding lookup port: compares a source register against the
// pending skid and main entries and returns the youngest matching result.
module wb_fwd_match
  import sparc_pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [REG_AW-1:0] rs_i,
  input  logic              skid_v_i,
  input  logic              skid_le_i,
  input  logic [REG_AW-1:0] skid_rd_i,
  input  logic [DATA_W-1:0] skid_data_i,
  input  logic              main_v_i,
  input  logic              main_le_i,
  input  logic [REG_AW-1:0] main_rd_i,
  input  logic [DATA_W-1:0] main_data_i,
  output logic              hit_o,
  output logic [DATA_W-1:0] data_o
);

  logic rsIsZero;
  logic skidMatch;
  logic mainMatch;

  assign rsIsZero  = is_zero_reg(REG_AW_MAX'(rs_i), ZERO_REG);
  assign skidMatch = skid_v_i & skid_le_i & (skid_rd_i == rs_i) & ~rsIsZero;
  assign mainMatch = main_v_i & main_le_i & (main_rd_i == rs_i) & ~rsIsZero;

  // Skid holds the younger entry, so it wins over main when both match.
  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    if (skidMatch) begin
      hit_o  = 1'b1;
      data_o = skid_data_i;
    end else if (mainMatch) begin
      hit_o  = 1'b1;
      data_o = main_data_i;
    end
  end

endmodule

// File: rtl/mem_wb_skid_stage.sv
// MEM->WB pipeline register with a two-entry skid buffer so that WB stalls
// never create a combinational ready path back into MEM. Also provides
// flush, hardwired-zero write suppression and operand forwarding lookups.
module mem_wb_skid_stage
  import sparc_pipe_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int REG_AW   = REG_AW_DEF,
  parameter int NUM_FWD  = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic                      clk,
  input  logic                      R,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_rf_le,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [REG_AW-1:0]         in_rd,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      out_rf_le,
  output logic [DATA_W-1:0]         out_data,
  output logic [REG_AW-1:0]         out_rd,
  input  logic [NUM_FWD*REG_AW-1:0] fwd_rs,
  output logic [NUM_FWD-1:0]        fwd_hit,
  output logic [NUM_FWD*DATA_W-1:0] fwd_data
);

  skid_state_e state_q, state_d;
  logic        in_ready_q;

  logic              main_le_q, main_le_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [REG_AW-1:0] main_rd_q, main_rd_d;
  logic              skid_le_q, skid_le_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [REG_AW-1:0] skid_rd_q, skid_rd_d;

  logic mainValid;
  logic skidValid;
  logic accept;
  logic retire;
  logic storeLe;
  logic loadMain;
  logic loadSkid;
  logic shiftSkid;

  assign mainValid = (state_q == SKID_ONE) | (state_q == SKID_FULL);
  assign skidValid = (state_q == SKID_FULL);
  assign accept    = in_valid & in_ready_q;
  assign retire    = mainValid & out_ready;
  assign storeLe   = in_rf_le & ~is_zero_reg(REG_AW_MAX'(in_rd), ZERO_REG);

  // Next state and bank load decisions; flush overrides every transition.
  always_comb begin
    state_d   = state_q;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    shiftSkid = 1'b0;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          state_d  = SKID_ONE;
          loadMain = 1'b1;
        end
      end
      SKID_ONE: begin
        if (accept & retire) begin
          loadMain = 1'b1;
        end else if (accept) begin
          state_d  = SKID_FULL;
          loadSkid = 1'b1;
        end else if (retire) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (retire) begin
          state_d   = SKID_ONE;
          shiftSkid = 1'b1;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
    if (flush) begin
      state_d   = SKID_EMPTY;
      loadMain  = 1'b0;
      loadSkid  = 1'b0;
      shiftSkid = 1'b0;
    end
  end

  // Entry bank contents follow the load decisions; skid empties when it moves to main.
  always_comb begin
    main_le_d   = main_le_q;
    main_data_d = main_data_q;
    main_rd_d   = main_rd_q;
    skid_le_d   = skid_le_q;
    skid_data_d = skid_data_q;
    skid_rd_d   = skid_rd_q;
    if (loadMain) begin
      main_le_d   = storeLe;
      main_data_d = in_data;
      main_rd_d   = in_rd;
    end
    if (loadSkid) begin
      skid_le_d   = storeLe;
      skid_data_d = in_data;
      skid_rd_d   = in_rd;
    end
    if (shiftSkid) begin
      main_le_d   = skid_le_q;
      main_data_d = skid_data_q;
      main_rd_d   = skid_rd_q;
      skid_le_d   = 1'b0;
      skid_data_d = '0;
      skid_rd_d   = '0;
    end
  end

  // State register and a registered ready that only drops once the skid is occupied.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_q    <= SKID_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != SKID_FULL);
    end
  end

  // Main and skid entry storage.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      main_le_q   <= 1'b0;
      main_data_q <= '0;
      main_rd_q   <= '0;
      skid_le_q   <= 1'b0;
      skid_data_q <= '0;
      skid_rd_q   <= '0;
    end else begin
      main_le_q   <= main_le_d;
      main_data_q <= main_data_d;
      main_rd_q   <= main_rd_d;
      skid_le_q   <= skid_le_d;
      skid_data_q <= skid_data_d;
      skid_rd_q   <= skid_rd_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = mainValid;
  assign out_rf_le = mainValid & main_le_q;
  assign out_data  = main_data_q;
  assign out_rd    = main_rd_q;

  for (genvar i = 0; i < NUM_FWD; i++) begin : g_fwd
    wb_fwd_match #(
      .DATA_W  (DATA_W),
      .REG_AW  (REG_AW),
      .ZERO_REG(ZERO_REG)
    ) u_match (
      .rs_i       (fwd_rs[i*REG_AW +: REG_AW]),
      .skid_v_i   (skidValid),
      .skid_le_i  (skid_le_q),
      .skid_rd_i  (skid_rd_q),
      .skid_data_i(skid_data_q),
      .main_v_i   (mainValid),
      .main_le_i  (main_le_q),
      .main_rd_i  (main_rd_q),
      .main_data_i(main_data_q),
      .hit_o      (fwd_hit[i]),
      .data_o     (fwd_data[i*DATA_W +: DATA_W])
    );
  end

endmodule

// File: tb/tb_mem_wb_skid_stage.sv
// Directed testbench for mem_wb_skid_stage with hand-computed expectations.
module tb_mem_wb_skid_stage;

  logic        clk;
  logic        R;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_rf_le;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        out_valid;
  logic        out_ready;
  logic        out_rf_le;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [9:0]  fwd_rs;
  logic [1:0]  fwd_hit;
  logic [63:0] fwd_data;

  int checkCount = 0;
  int passCount  = 0;

  mem_wb_skid_stage #(
    .DATA_W  (32),
    .REG_AW  (5),
    .NUM_FWD (2),
    .ZERO_REG(1'b1)
  ) dut (
    .clk      (clk),
    .R        (R),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_rf_le (in_rf_le),
    .in_data  (in_data),
    .in_rd    (in_rd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_rf_le(out_rf_le),
    .out_data (out_data),
    .out_rd   (out_rd),
    .fwd_rs   (fwd_rs),
    .fwd_hit  (fwd_hit),
    .fwd_data (fwd_data)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Drive one MEM entry (or idle when valid is 0).
  task automatic applyStimulus(input logic v, input logic le, input logic [4:0] rd,
                               input logic [31:0] data);
    in_valid = v;
    in_rf_le = le;
    in_rd    = rd;
    in_data  = data;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    R         = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    fwd_rs    = '0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);

    // Reset held with random inputs
    for (int i = 0; i < 3; i++) begin
      tick();
      applyStimulus(1'($urandom), 1'($urandom), 5'($urandom), $urandom);
      out_ready = 1'($urandom);
      flush     = 1'($urandom);
      fwd_rs    = 10'($urandom);
      #1;
      checkOutput("rst_out_valid", 32'(out_valid), 32'h0);
      checkOutput("rst_out_rf_le", 32'(out_rf_le), 32'h0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
      checkOutput("rst_fwd_hit", 32'(fwd_hit), 32'h0);
    end
    checkOutput("rst_out_data", out_data, 32'h0);
    checkOutput("rst_fwd_data", fwd_data[31:0], 32'h0);

    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    out_ready = 1'b1;
    flush     = 1'b0;
    fwd_rs    = '0;
    R         = 1'b1;
    tick();
    checkOutput("post_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("post_rst_ready", 32'(in_ready), 32'h1);

    // Streaming: one entry per cycle, each visible one cycle later
    out_ready = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      if (i > 1) begin
        checkOutput("stream_valid", 32'(out_valid), 32'h1);
        checkOutput("stream_rd", 32'(out_rd), 32'(i - 1));
        checkOutput("stream_data", out_data, 32'(32'h100 + i - 1));
        checkOutput("stream_rf_le", 32'(out_rf_le), 32'h1);
      end
      checkOutput("stream_in_ready", 32'(in_ready), 32'h1);
      if (i <= 8) applyStimulus(1'b1, 1'b1, 5'(i), 32'(32'h100 + i));
      else        applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
      tick();
    end
    checkOutput("stream_drained", 32'(out_valid), 32'h0);

    // Backpressure: A, B accepted, C held by MEM until space returns
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd10, 32'h0A0A);
    tick();
    checkOutput("bp_ready_c2", 32'(in_ready), 32'h1);
    applyStimulus(1'b1, 1'b1, 5'd11, 32'h0B0B);
    tick();
    checkOutput("bp_ready_c3", 32'(in_ready), 32'h0);
    applyStimulus(1'b1, 1'b1, 5'd12, 32'h0C0C);
    tick();
    checkOutput("bp_ready_c4", 32'(in_ready), 32'h0);
    checkOutput("bp_hold_rd_a", 32'(out_rd), 32'd10);
    checkOutput("bp_hold_data_a", out_data, 32'h0A0A);
    out_ready = 1'b1;
    tick();
    checkOutput("bp_rd_b", 32'(out_rd), 32'd11);
    checkOutput("bp_ready_back", 32'(in_ready), 32'h1);
    tick();
    checkOutput("bp_rd_c", 32'(out_rd), 32'd12);
    checkOutput("bp_data_c", out_data, 32'h0C0C);
    checkOutput("bp_valid_c", 32'(out_valid), 32'h1);
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("bp_drained", 32'(out_valid), 32'h0);

    // Flush while FULL with an entry offered
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd20, 32'h2020);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd21, 32'h2121);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd22, 32'h2222);
    fwd_rs = {5'd0, 5'd21};
    #1;
    checkOutput("fl_full_ready", 32'(in_ready), 32'h0);
    checkOutput("fl_pre_hit", 32'(fwd_hit[0]), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("fl_valid", 32'(out_valid), 32'h0);
    checkOutput("fl_ready", 32'(in_ready), 32'h1);
    checkOutput("fl_hit", 32'(fwd_hit), 32'h0);
    out_ready = 1'b1;
    tick();
    checkOutput("fl_no_reappear", 32'(out_valid), 32'h0);
    // Flush from EMPTY discards a same-cycle accept
    applyStimulus(1'b1, 1'b1, 5'd23, 32'h2323);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("fl_accept_dropped", 32'(out_valid), 32'h0);

    // Forwarding priority and qualification
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hAAAA);
    tick();
    applyStimulus(1'b1, 1'b1, 5'd5, 32'hBBBB);
    fwd_rs = {5'd6, 5'd5};
    #1;
    checkOutput("fwd_main_hit", 32'(fwd_hit[0]), 32'h1);
    checkOutput("fwd_main_data", fwd_data[31:0], 32'hAAAA);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("fwd_skid_hit", 32'(fwd_hit[0]), 32'h1);
    checkOutput("fwd_skid_data", fwd_data[31:0], 32'hBBBB);
    checkOutput("fwd_miss_hit", 32'(fwd_hit[1]), 32'h0);
    checkOutput("fwd_miss_data", fwd_data[63:32], 32'h0);
    checkOutput("fwd_out_data", out_data, 32'hAAAA);
    out_ready = 1'b1;
    tick();
    checkOutput("fwd_shift_data", out_data, 32'hBBBB);
    checkOutput("fwd_shift_fwd", fwd_data[31:0], 32'hBBBB);
    tick();
    checkOutput("fwd_empty_hit", 32'(fwd_hit[0]), 32'h0);
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b0, 5'd5, 32'h1234);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    checkOutput("nole_valid", 32'(out_valid), 32'h1);
    checkOutput("nole_rf_le", 32'(out_rf_le), 32'h0);
    checkOutput("nole_hit", 32'(fwd_hit[0]), 32'h0);
    checkOutput("nole_data", fwd_data[31:0], 32'h0);
    out_ready = 1'b1;
    tick();

    // Register 0 writes are suppressed and never forwarded
    out_ready = 1'b0;
    applyStimulus(1'b1, 1'b1, 5'd0, 32'hFFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0);
    fwd_rs = {5'd5, 5'd0};
    #1;
    checkOutput("g0_valid", 32'(out_valid), 32'h1);
    checkOutput("g0_rf_le", 32'(out_rf_le), 32'h0);
    checkOutput("g0_data", out_data, 32'hFFFF);
    checkOutput("g0_hit", 32'(fwd_hit), 32'h0);
    out_ready = 1'b1;
    tick();
    checkOutput("g0_drained", 32'(out_valid), 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
